// File: rtl/seq_det_scheduler_pkg.sv
// Shared definitions for the sequence-detector scheduler.
//   state_e : FSM state encodings (IDLE, CLR, SHIFT, DRAIN, DONE)
//   id_w    : width of a requester index for n requesters
//   cnt_w   : width of a hit counter able to hold 0..fw
package seq_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Index width; a single requester still needs one bit to avoid zero-width vectors.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int fw);
    return $clog2(fw + 1);
  endfunction

endpackage

// File: rtl/seq_det_scheduler_if.sv
// Client-side bus of the sequence-detector scheduler.
//   req, frame_data         : requester -> scheduler (frame i at [i*FRAME_W +: FRAME_W])
//   gnt, busy, done,
//   done_id, hit_cnt        : scheduler -> requesters
// Modports: master = requester side, slave = scheduler side.
interface seq_det_scheduler_if
  import seq_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int FRAME_W = 8
);
  localparam int ID_W  = id_w(N_REQ);
  localparam int CNT_W = cnt_w(FRAME_W);

  logic [N_REQ-1:0]         req;
  logic [N_REQ*FRAME_W-1:0] frame_data;
  logic [N_REQ-1:0]         gnt;
  logic                     busy;
  logic                     done;
  logic [ID_W-1:0]          done_id;
  logic [CNT_W-1:0]         hit_cnt;

  modport master (
    output req, frame_data,
    input  gnt, busy, done, done_id, hit_cnt
  );

  modport slave (
    input  req, frame_data,
    output gnt, busy, done, done_id, hit_cnt
  );
endinterface

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
//   req_i  : request vector
//   ptr_i  : index that has highest priority this round
//   pick_o : one-hot winner
//   idx_o  : binary index of winner
//   any_o  : at least one request present
// The pointer register lives in the parent.
module rr_arbiter
  import seq_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  logic [ID_W:0]   sum_s;
  logic [ID_W-1:0] cand_s;

  // Scan from ptr upward with wrap; the first set request wins.
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    sum_s  = '0;
    cand_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum_s = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (sum_s >= (ID_W+1)'(N_REQ)) begin
        sum_s = sum_s - (ID_W+1)'(N_REQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[ID_W-1:0];
      if (!any_o && req_i[cand_s]) begin
        pick_o[cand_s] = 1'b1;
        idx_o          = cand_s;
        any_o          = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Time-shares one external Moore sequence detector between N_REQ requesters.
// A round-robin winner's frame is latched, the detector is cleared, the frame
// is shifted in MSB first, and detector hits over the observation window are
// reported with the requester id.
//   clk, rst : clock, synchronous active-high reset
//   bus      : client bus (slave modport) - req/frame_data in, gnt/busy/done/done_id/hit_cnt out
//   det_clr  : detector clear (also forced high while rst is high)
//   det_in   : serial bit to detector
//   det_out  : detector match output
module seq_det_scheduler
  import seq_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int FRAME_W = 8,
  parameter int DET_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  seq_det_scheduler_if.slave bus,
  output logic               det_clr,
  output logic               det_in,
  input  logic               det_out
);

  localparam int ID_W  = id_w(N_REQ);
  localparam int CNT_W = cnt_w(FRAME_W);
  localparam int IDX_W = $clog2(FRAME_W + DET_LAT);

  // idx counts the SHIFT cycles and then continues through DRAIN.
  localparam logic [IDX_W-1:0] IDX_LAST_SHIFT = IDX_W'(FRAME_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(FRAME_W + DET_LAT - 1);
  localparam logic [IDX_W-1:0] IDX_WIN        = IDX_W'(DET_LAT);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     cur_id_q, cur_id_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    hit_q, hit_d;

  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                det_clr_q, det_clr_d;
  logic                det_in_q, det_in_d;
  logic                done_q, done_d;
  logic [ID_W-1:0]     done_id_q, done_id_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;

  logic [N_REQ-1:0]    arb_pick_s;
  logic [ID_W-1:0]     arb_idx_s;
  logic                arb_any_s;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i  (bus.req),
    .ptr_i  (ptr_q),
    .pick_o (arb_pick_s),
    .idx_o  (arb_idx_s),
    .any_o  (arb_any_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; req is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) state_d = ST_CLR;
        else           state_d = ST_IDLE;
      end
      ST_CLR:   state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (idx_q == IDX_LAST_SHIFT) state_d = ST_DRAIN;
        else                         state_d = ST_SHIFT;
      end
      ST_DRAIN: begin
        if (idx_q == IDX_LAST) state_d = ST_DONE;
        else                   state_d = ST_DRAIN;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: frame latch, shift register, window index, hit counter, pointer.
  always_comb begin
    shreg_d  = shreg_q;
    cur_id_d = cur_id_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) begin
          cur_id_d = arb_idx_s;
          for (int k = 0; k < N_REQ; k++) begin
            if (arb_idx_s == ID_W'(k)) shreg_d = bus.frame_data[k*FRAME_W +: FRAME_W];
            else                       shreg_d = shreg_d;
          end
        end else begin
          cur_id_d = cur_id_q;
        end
      end
      ST_CLR: begin
        idx_d = '0;
        hit_d = '0;
        if (cur_id_q == ID_W'(N_REQ - 1)) ptr_d = '0;
        else                              ptr_d = cur_id_q + ID_W'(1);
      end
      ST_SHIFT, ST_DRAIN: begin
        idx_d = idx_q + IDX_W'(1);
        if (state_q == ST_SHIFT) shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
        else                     shreg_d = shreg_q;
        // det_out lags det_in by DET_LAT, so the window starts DET_LAT cycles in.
        if (idx_q >= IDX_WIN) hit_d = hit_q + CNT_W'(det_out);
        else                  hit_d = hit_q;
      end
      default: begin
        idx_d = idx_q;
      end
    endcase
  end

  // FSM output decode; outputs are registered, so decode the upcoming state.
  always_comb begin
    busy_d    = (state_d != ST_IDLE);
    det_clr_d = (state_d == ST_CLR);
    done_d    = (state_d == ST_DONE);
    done_id_d = done_id_q;
    hit_cnt_d = hit_cnt_q;
    // CLR is only reachable from IDLE, so the grant is the arbiter pick on that transition.
    if (state_q == ST_IDLE && arb_any_s) gnt_d = arb_pick_s;
    else                                 gnt_d = '0;
    if (state_d == ST_SHIFT) det_in_d = shreg_d[FRAME_W-1];
    else                     det_in_d = 1'b0;
    // hit_d already includes the last window sample taken in the final DRAIN cycle.
    if (state_d == ST_DONE) begin
      done_id_d = cur_id_q;
      hit_cnt_d = hit_d;
    end else begin
      done_id_d = done_id_q;
      hit_cnt_d = hit_cnt_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      cur_id_q  <= '0;
      shreg_q   <= '0;
      idx_q     <= '0;
      hit_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      det_clr_q <= 1'b0;
      det_in_q  <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      cur_id_q  <= cur_id_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      det_clr_q <= det_clr_d;
      det_in_q  <= det_in_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  // Detector is held cleared for the whole reset, including before the first edge.
  assign det_clr     = det_clr_q | rst;
  assign det_in      = det_in_q;
  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
module tb_seq_det_scheduler;
  localparam int N_REQ   = 4;
  localparam int FRAME_W = 8;
  localparam int DET_LAT = 1;

  typedef struct {
    int id;
    int hits;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic det_clr, det_in, det_out;

  int   total = 0;
  int   bad   = 0;
  int   done_seen = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] frm [4];
  logic [1:0] det_st;

  always #5 clk = ~clk;

  seq_det_scheduler_if #(.N_REQ(N_REQ), .FRAME_W(FRAME_W)) bus_if ();

  seq_det_scheduler #(.N_REQ(N_REQ), .FRAME_W(FRAME_W), .DET_LAT(DET_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if.slave),
    .det_clr (det_clr),
    .det_in  (det_in),
    .det_out (det_out)
  );

  // Behavioural Moore "101" overlapping detector: 0=idle, 1=saw 1, 2=saw 10, 3=saw 101.
  always @(posedge clk) begin
    if (det_clr) det_st <= 2'd0;
    else begin
      case (det_st)
        2'd0:    det_st <= det_in ? 2'd1 : 2'd0;
        2'd1:    det_st <= det_in ? 2'd1 : 2'd2;
        2'd2:    det_st <= det_in ? 2'd3 : 2'd0;
        default: det_st <= det_in ? 2'd1 : 2'd2;
      endcase
    end
  end
  assign det_out = (det_st == 2'd3);

  // Number of "101" patterns ending within the frame, bits taken MSB first.
  function automatic int count_101(input logic [7:0] f);
    int c = 0;
    for (int k = 2; k < 8; k++)
      if (f[9-k] == 1'b1 && f[8-k] == 1'b0 && f[7-k] == 1'b1) c++;
    return c;
  endfunction

  // Scoreboard: every done pops the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && bus_if.done === 1'b1) begin
      done_seen++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: got id=%0d hits=%0d, expected no completion",
                 bus_if.done_id, bus_if.hit_cnt);
      end else begin
        mon_e = sb.pop_front();
        if (bus_if.done_id !== 2'(mon_e.id) || bus_if.hit_cnt !== 4'(mon_e.hits)) begin
          bad++;
          $display("FAIL sb_done: got id=%0d hits=%0d, expected id=%0d hits=%0d",
                   bus_if.done_id, bus_if.hit_cnt, mon_e.id, mon_e.hits);
        end
      end
    end
  end

  task automatic drive_frames();
    bus_if.frame_data = {frm[3], frm[2], frm[1], frm[0]};
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id   = id;
    e.hits = count_101(frm[id]);
    sb.push_back(e);
  endtask

  task automatic wait_gnt(output logic [3:0] g, output int n);
    int k = 0;
    g = 4'b0000;
    n = -1;
    while (n < 0 && k < 40) begin
      k++;
      @(negedge clk);
      if (bus_if.gnt !== 4'b0000) begin
        g = bus_if.gnt;
        n = k;
      end
    end
  endtask

  task automatic wait_done(output int n);
    int k = 0;
    n = -1;
    while (n < 0 && k < 40) begin
      k++;
      @(negedge clk);
      if (bus_if.done === 1'b1) n = k;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus_if.req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] g;
    int n;
    rst = 1'b1;
    frm[0] = 8'b1011_0101; frm[1] = 8'h11; frm[2] = 8'h22; frm[3] = 8'h33;
    drive_frames();
    bus_if.req = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (bus_if.gnt !== 4'b0000 || bus_if.done !== 1'b0 || det_clr !== 1'b1) begin
        bad++;
        $display("FAIL reset_hold: got gnt=%b done=%b det_clr=%b, expected 0000/0/1",
                 bus_if.gnt, bus_if.done, det_clr);
      end
    end
    total++;
    if (bus_if.busy !== 1'b0 || det_in !== 1'b0 || bus_if.done_id !== 2'd0 || bus_if.hit_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_regs: got busy=%b det_in=%b done_id=%0d hit_cnt=%0d, expected all 0",
               bus_if.busy, det_in, bus_if.done_id, bus_if.hit_cnt);
    end
    push_exp(0);
    rst = 1'b0;
    wait_gnt(g, n);
    bus_if.req = 4'b0000;
    total++;
    if (g !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_gnt: got %b, expected 0001", g);
    end
    wait_done(n);
  endtask

  task automatic test_single();
    logic [3:0] g;
    int n;
    frm[0] = 8'b1010_1010;
    drive_frames();
    push_exp(0);
    bus_if.req = 4'b0001;
    wait_gnt(g, n);
    bus_if.req = 4'b0000;
    total++;
    if (g !== 4'b0001 || bus_if.busy !== 1'b1 || det_clr !== 1'b1) begin
      bad++;
      $display("FAIL single_gnt: got gnt=%b busy=%b det_clr=%b, expected 0001/1/1", g, bus_if.busy, det_clr);
    end
    wait_done(n);
    total++;
    if (n !== 10) begin
      bad++;
      $display("FAIL single_latency: got %0d cycles, expected 10", n);
    end
    total++;
    if (bus_if.hit_cnt !== 4'd3 || bus_if.done_id !== 2'd0) begin
      bad++;
      $display("FAIL single_result: got hits=%0d id=%0d, expected 3/0", bus_if.hit_cnt, bus_if.done_id);
    end
    @(negedge clk);
    total++;
    if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.hit_cnt !== 4'd3) begin
      bad++;
      $display("FAIL single_after: got done=%b busy=%b hits=%0d, expected 0/0/3 held",
               bus_if.done, bus_if.busy, bus_if.hit_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    int n;
    apply_reset();
    frm[0] = 8'hFF; frm[1] = 8'h00; frm[2] = 8'b1010_1101; frm[3] = 8'h05;
    drive_frames();
    for (int k = 0; k < 4; k++) push_exp(k);
    bus_if.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g, n);
      bus_if.req[k] = 1'b0;
      total++;
      if (g !== 4'(1 << k)) begin
        bad++;
        $display("FAIL rr_order: grant %0d got %b, expected %b", k, g, 4'(1 << k));
      end
      if (k > 0) begin
        total++;
        if (n !== 12) begin
          bad++;
          $display("FAIL rr_period: grant %0d got gap %0d, expected 12", k, n);
        end
      end
    end
    wait_done(n);
    total++;
    if (bus_if.hit_cnt !== 4'd1 || bus_if.done_id !== 2'd3) begin
      bad++;
      $display("FAIL rr_last: got hits=%0d id=%0d, expected 1/3", bus_if.hit_cnt, bus_if.done_id);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] g;
    int n;
    frm[1] = 8'h5A; frm[2] = 8'hAA; frm[3] = 8'h2D;
    drive_frames();
    push_exp(2);
    bus_if.req = 4'b0100;
    wait_gnt(g, n);
    bus_if.req = 4'b0000;
    total++;
    if (g !== 4'b0100) begin
      bad++;
      $display("FAIL wrap_prep: got %b, expected 0100", g);
    end
    wait_done(n);
    push_exp(3);
    push_exp(1);
    bus_if.req = 4'b1010;
    wait_gnt(g, n);
    bus_if.req[3] = 1'b0;
    total++;
    if (g !== 4'b1000) begin
      bad++;
      $display("FAIL wrap_first: got %b, expected 1000", g);
    end
    wait_gnt(g, n);
    bus_if.req[1] = 1'b0;
    total++;
    if (g !== 4'b0010 || n !== 12) begin
      bad++;
      $display("FAIL wrap_second: got %b after %0d, expected 0010 after 12", g, n);
    end
    wait_done(n);
  endtask

  task automatic test_abort();
    logic [3:0] g;
    int n;
    int seen0;
    int stray;
    frm[0] = 8'b1010_1010; frm[2] = 8'b1010_1010; frm[3] = 8'h00;
    drive_frames();
    bus_if.req = 4'b0100;
    wait_gnt(g, n);
    bus_if.req = 4'b0000;
    total++;
    if (g !== 4'b0100) begin
      bad++;
      $display("FAIL abort_gnt: got %b, expected 0100", g);
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen0 = done_seen;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) stray++;
    end
    total++;
    if (stray !== 0 || done_seen !== seen0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d busy/done cycles, expected 0", stray);
    end
    total++;
    if (bus_if.done_id !== 2'd0 || bus_if.hit_cnt !== 4'd0) begin
      bad++;
      $display("FAIL abort_regs: got id=%0d hits=%0d, expected 0/0", bus_if.done_id, bus_if.hit_cnt);
    end
    push_exp(0);
    push_exp(3);
    bus_if.req = 4'b1001;
    wait_gnt(g, n);
    bus_if.req[0] = 1'b0;
    total++;
    if (g !== 4'b0001) begin
      bad++;
      $display("FAIL abort_ptr: got %b, expected 0001", g);
    end
    wait_done(n);
    total++;
    if (bus_if.hit_cnt !== 4'd3) begin
      bad++;
      $display("FAIL abort_clean: got hits=%0d, expected 3", bus_if.hit_cnt);
    end
    wait_gnt(g, n);
    bus_if.req[3] = 1'b0;
    wait_done(n);
  endtask

  task automatic test_drain_hit();
    logic [3:0] g;
    int n;
    int stray;
    frm[1] = 8'b0000_0101;
    drive_frames();
    push_exp(1);
    bus_if.req = 4'b0010;
    wait_gnt(g, n);
    bus_if.req = 4'b0000;
    repeat (3) @(negedge clk);
    bus_if.req[3] = 1'b1;
    @(negedge clk);
    bus_if.req[3] = 1'b0;
    wait_done(n);
    total++;
    if (n < 0 || bus_if.hit_cnt !== 4'd1 || bus_if.done_id !== 2'd1) begin
      bad++;
      $display("FAIL drain_hit: got hits=%0d id=%0d wait=%0d, expected 1/1", bus_if.hit_cnt, bus_if.done_id, n);
    end
    stray = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus_if.gnt !== 4'b0000) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL dropped_req: got %0d grant cycles, expected 0", stray);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_if.req = 4'b0000;
    bus_if.frame_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_abort();
    test_drain_hit();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_empty: got %0d outstanding, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
